ed25519_sig_serializer: RTL and testbench
=========================================

// Module: ed25519_sig_serializer
// PURPOSE
//  Downstream of ed25519_sign_S_core. Captures the scalar S (core_S, valid on core_comp_done)
//  together with the encoded point R, and emits the 64-byte Ed25519 signature R||S as a
//  valid/ready word stream toward the host/DMA interface. Holds one signature at a time and
//  backpressures the core through cap_ready.
// PARAMETERS
//  WORD_W  32  output word width in bits; one of 8/16/32/64 (elaboration error otherwise)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  cap_valid    in   1       capture strobe (wired to core_comp_done)
//  cap_ready    out  1       serializer idle, capture will be taken
//  core_S       in   256     S as integer, byte 0 (LSB) = core_S[7:0]
//  sig_R        in   256     encoded R as byte string, byte 0 = sig_R[255:248]
//  out_valid    out  1       out_data holds a valid word
//  out_ready    in   1       downstream accepts word
//  out_data     out  WORD_W  signature bytes; earliest byte in MSBs of the word
//  out_last     out  1       high with the final word (word 512/WORD_W-1)
//  overrun      out  1       sticky: cap_valid seen while busy; cleared only by reset
//  s_range_err  out  1       1-cycle pulse: captured S >= L (SIG_RANGE_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, word counter 0, holding reg 0, cap_ready=1 after
//    release; out_valid/out_last/out_data/overrun/s_range_err all 0.
//  - States: IDLE -> SEND on cap_valid&&cap_ready; SEND -> IDLE on out_valid&&out_ready&&out_last.
//  - Capture: 512-bit holding reg loads {sig_R, byte-reversed core_S} so sig bytes 0..63 run
//    MSB->LSB. First word valid the cycle after capture (latency 1); cap_ready=0 in SEND.
//  - Stream: word k = hold[511-k*WORD_W -: WORD_W]; counter advances only on out_valid&&out_ready;
//    out_data/out_last stable while out_valid && !out_ready. 512/WORD_W words per signature.
//  - Last-word accept returns to IDLE with cap_ready=1 next cycle; back-to-back capture allowed
//    that cycle (no bubble beyond the IDLE cycle).
//  - cap_valid while in SEND: ignored, overrun<=1, stream continues unaffected.
//  - cap_valid is treated as a level; each cycle it is high in IDLE is a new capture.
//  - Reset mid-stream: stream aborted, no out_last emitted; downstream must discard partial.
// CONFIGURATION
//  SIG_RANGE_CHECK_EN defined: on capture, S compared with L = 2^252 +
//   27742317777372353535851937790883648493; if S >= L, capture dropped (stay IDLE, cap_ready
//   stays 1, no words), s_range_err pulses 1 cycle after cap_valid.
//  Undefined: no compare logic; every capture streams; s_range_err tied 0.
// STRUCTURE
//  ed25519_pkg: ED25519_L (256-bit constant), SIG_BYTES=64, state encoding localparams,
//   byte-reverse-256 function (shared with core's changeEndian helpers).
//  Sub-module ed25519_s_range_chk (256-bit S >= L comparator), instantiated only under macro.
// TESTING
//  1 WORD_W=32, R=0x000102..1f, S=1, out_ready=1 -> words 0x00010203..0x1c1d1e1f, then
//    0x01000000, 7x 0x00000000; out_last on word 15 only; cap_ready=1 next cycle.
//  2 Same stimulus, out_ready=0 for 5 cycles at word 3 -> out_data=0x0c0d0e0f held stable,
//    stream resumes with word 4, 16 words total.
//  3 Second cap_valid 4 cycles into stream -> overrun=1 (sticky), first signature intact,
//    second capture not streamed.
//  4 rst_n low at word 9 -> all outputs 0 asynchronously; after release new capture streams
//    from word 0.
//  5 SIG_RANGE_CHECK_EN: S=L -> s_range_err pulse, no out_valid; S=L-1 -> full 16-word stream.
//  6 WORD_W=8, S=0x0102..20 (byte0=0x20) -> 32 R bytes then 0x20,0x1f..0x01; out_last on byte 63.

Source files
------------

// File: rtl/ed25519_sig_serializer_pkg.sv
// Shared constants, state encoding and byte-order helper for the Ed25519 signature path.
// Used by the serializer, its interface and the optional S range checker.
package ed25519_sig_serializer_pkg;

    // Group order L = 2^252 + 27742317777372353535851937790883648493
    localparam logic [255:0] ED25519_L =
        256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    localparam int SIG_BYTES = 64;
    localparam int SIG_BITS  = SIG_BYTES * 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    // Integer (LSB-first bytes) <-> byte string (first byte in MSBs)
    function automatic logic [255:0] byte_rev256(input logic [255:0] v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = v[255-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ed25519_sig_serializer_if.sv
// Capture and word-stream signals between the S core/host side and the signature serializer.
// The master modport is the environment's view; the slave modport is the serializer's view.
interface ed25519_sig_serializer_if #(
    parameter int WORD_W = 32
);
    logic              cap_valid;
    logic              cap_ready;
    logic [255:0]      core_S;
    logic [255:0]      sig_R;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              overrun;
    logic              s_range_err;

    modport master (
        output cap_valid, core_S, sig_R, out_ready,
        input  cap_ready, out_valid, out_data, out_last, overrun, s_range_err
    );

    modport slave (
        input  cap_valid, core_S, sig_R, out_ready,
        output cap_ready, out_valid, out_data, out_last, overrun, s_range_err
    );

endinterface

// File: rtl/ed25519_sig_serializer_s_range_chk.sv
// Flags a captured scalar S that is not reduced modulo the group order L.
// Instantiated by the serializer only when SIG_RANGE_CHECK_EN is defined.
module ed25519_s_range_chk
    import ed25519_sig_serializer_pkg::*;
(
    input  logic [255:0] s,
    output logic         s_ge_l
);

    assign s_ge_l = (s >= ED25519_L);

endmodule

// File: rtl/ed25519_sig_serializer.sv
// Captures S and R, then streams the 64-byte signature R||S as WORD_W-bit words.
// Optional feature: define SIG_RANGE_CHECK_EN to drop captures with S >= L and pulse s_range_err.
module ed25519_sig_serializer
    import ed25519_sig_serializer_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ed25519_sig_serializer_if.slave bus
);

    localparam int NWORDS = SIG_BITS / WORD_W;
    localparam int CNT_W  = $clog2(NWORDS);

    if (WORD_W != 8 && WORD_W != 16 && WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("ed25519_sig_serializer: WORD_W must be 8, 16, 32 or 64");
    end

    ser_state_e        state;
    logic [511:0]      hold;
    logic [CNT_W-1:0]  cnt;
    logic              cap_ready_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              overrun_q;
    logic              s_ge_l;

`ifdef SIG_RANGE_CHECK_EN
    logic range_err_q;

    ed25519_s_range_chk u_range_chk (
        .s      (bus.core_S),
        .s_ge_l (s_ge_l)
    );
`else
    assign s_ge_l = 1'b0;
`endif

    logic cap_fire;
    logic take;
    logic beat;

    assign cap_fire = bus.cap_valid && (state == ST_IDLE);
    assign take     = cap_fire && !s_ge_l;
    assign beat     = out_valid_q && bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments and an async reset branch only;
    // every register here, including the 512-bit holding register, has a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hold        <= '0;
            cnt         <= '0;
            cap_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (bus.cap_valid && (state == ST_SEND)) begin
                overrun_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        hold        <= {bus.sig_R, byte_rev256(bus.core_S)};
                        cnt         <= '0;
                        state       <= ST_SEND;
                        cap_ready_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // The current word always sits in the top WORD_W bits; shifting keeps the
                    // output mux-free and leaves the register zeroed once the stream ends.
                    if (beat) begin
                        hold <= hold << WORD_W;
                        if (out_last_q) begin
                            state       <= ST_IDLE;
                            cap_ready_q <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            cnt        <= cnt + CNT_W'(1);
                            out_last_q <= (cnt == CNT_W'(NWORDS - 2));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SIG_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= cap_fire && s_ge_l;
        end
    end

    assign bus.s_range_err = range_err_q;
`else
    assign bus.s_range_err = 1'b0;
`endif

    assign bus.cap_ready = cap_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = hold[511 -: WORD_W];
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_ed25519_sig_serializer.sv
// Self-checking bench: a queue-based scoreboard for a 32-bit and an 8-bit serializer instance.
// Covers latency, backpressure, overrun, mid-stream reset and the optional S range check.
module tb_ed25519_sig_serializer;

    localparam logic [255:0] L_VAL =
        256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t       q32[$];
    beat_t       q8[$];
    logic [63:0] obs32[$];
    logic [63:0] obs8[$];

    ed25519_sig_serializer_if #(.WORD_W(32)) i32 ();
    ed25519_sig_serializer_if #(.WORD_W(8))  i8  ();

    ed25519_sig_serializer #(.WORD_W(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i32.slave)
    );

    ed25519_sig_serializer #(.WORD_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signature byte i of R||S: R is a byte string, S an LSB-first integer
    function automatic logic [7:0] sig_byte(input logic [255:0] r, input logic [255:0] s, input int i);
        if (i < 32) return r[255-8*i -: 8];
        return s[8*(i-32) +: 8];
    endfunction

    task automatic push_sig32(input logic [255:0] r, input logic [255:0] s);
        beat_t b;
        obs32.delete();
        for (int k = 0; k < 16; k++) begin
            b.data = '0;
            for (int j = 0; j < 4; j++) b.data = {b.data[55:0], sig_byte(r, s, 4*k + j)};
            b.last = (k == 15);
            q32.push_back(b);
        end
    endtask

    task automatic push_sig8(input logic [255:0] r, input logic [255:0] s);
        beat_t b;
        obs8.delete();
        for (int k = 0; k < 64; k++) begin
            b.data = {56'd0, sig_byte(r, s, k)};
            b.last = (k == 63);
            q8.push_back(b);
        end
    endtask

    // Scoreboard: compare every accepted word against the oldest expected one
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (i32.out_valid && i32.out_ready) begin
                obs32.push_back(64'(i32.out_data));
                if (q32.size() == 0) begin
                    check("w32_unexpected_word", 64'(i32.out_data), 64'hdead);
                end else begin
                    e = q32.pop_front();
                    check("w32_data", 64'(i32.out_data), e.data);
                    check("w32_last", 64'(i32.out_last), 64'(e.last));
                end
            end
            if (i8.out_valid && i8.out_ready) begin
                obs8.push_back(64'(i8.out_data));
                if (q8.size() == 0) begin
                    check("w8_unexpected_word", 64'(i8.out_data), 64'hdead);
                end else begin
                    e = q8.pop_front();
                    check("w8_data", 64'(i8.out_data), e.data);
                    check("w8_last", 64'(i8.out_last), 64'(e.last));
                end
            end
        end
    end

    task automatic cap32(input logic [255:0] r, input logic [255:0] s, input bit streams);
        @(posedge clk); #1;
        i32.sig_R     = r;
        i32.core_S    = s;
        i32.cap_valid = 1'b1;
        if (streams) push_sig32(r, s);
        @(posedge clk); #1;
        i32.cap_valid = 1'b0;
    endtask

    task automatic drain32(input string tag);
        for (int i = 0; i < 400 && q32.size() != 0; i++) @(posedge clk);
        check(tag, 64'(q32.size()), 64'd0);
    endtask

    task automatic wait_obs32(input int n);
        for (int i = 0; i < 400 && obs32.size() < n; i++) @(posedge clk);
        check("w32_progress", 64'(obs32.size()), 64'(n));
    endtask

    logic [255:0] r_seq;
    logic [255:0] s_one;
    logic [255:0] s_desc;

    initial begin
        for (int i = 0; i < 32; i++) begin
            r_seq[255-8*i -: 8] = 8'(i);
            s_desc[8*i +: 8]    = 8'(32 - i);
        end
        s_one = 256'd1;

        rst_n         = 1'b0;
        i32.cap_valid = 1'b0;
        i32.core_S    = '0;
        i32.sig_R     = '0;
        i32.out_ready = 1'b1;
        i8.cap_valid  = 1'b0;
        i8.core_S     = '0;
        i8.sig_R      = '0;
        i8.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_cap_ready",   64'(i32.cap_ready),   64'd1);
        check("rst_out_valid",   64'(i32.out_valid),   64'd0);
        check("rst_out_last",    64'(i32.out_last),    64'd0);
        check("rst_out_data",    64'(i32.out_data),    64'd0);
        check("rst_overrun",     64'(i32.overrun),     64'd0);
        check("rst_s_range_err", 64'(i32.s_range_err), 64'd0);

        // Plain stream, latency 1, return to idle
        cap32(r_seq, s_one, 1'b1);
        @(negedge clk);
        check("t1_latency_valid", 64'(i32.out_valid), 64'd1);
        check("t1_cap_ready_busy", 64'(i32.cap_ready), 64'd0);
        drain32("t1_drain");
        @(negedge clk);
        check("t1_idle_cap_ready", 64'(i32.cap_ready), 64'd1);
        check("t1_idle_valid",     64'(i32.out_valid), 64'd0);
        check("t1_word_count",     64'(obs32.size()),  64'd16);
        check("t1_word0",          obs32[0],           64'h00010203);
        check("t1_word8",          obs32[8],           64'h01000000);

        // Backpressure at word 3
        cap32(r_seq, s_one, 1'b1);
        wait_obs32(3);
        #1 i32.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_stall_valid", 64'(i32.out_valid), 64'd1);
            check("t2_stall_data",  64'(i32.out_data),  64'h0c0d0e0f);
            check("t2_stall_last",  64'(i32.out_last),  64'd0);
        end
        @(posedge clk); #1 i32.out_ready = 1'b1;
        drain32("t2_drain");
        check("t2_word_count", 64'(obs32.size()), 64'd16);

        // Capture during SEND: overrun, stream unaffected
        cap32(r_seq, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'h0}, 1'b1);
        repeat (3) @(posedge clk);
        cap32(~r_seq, s_one, 1'b0);
        @(negedge clk);
        check("t3_overrun", 64'(i32.overrun), 64'd1);
        drain32("t3_drain");
        repeat (4) begin
            @(negedge clk);
            check("t3_no_second_stream", 64'(i32.out_valid), 64'd0);
        end
        check("t3_overrun_sticky", 64'(i32.overrun), 64'd1);
        check("t3_word_count",     64'(obs32.size()), 64'd16);

        // Asynchronous reset mid-stream
        cap32(r_seq, s_desc, 1'b1);
        wait_obs32(9);
        #2 rst_n = 1'b0;
        q32.delete();
        #1;
        check("t4_rst_valid",   64'(i32.out_valid), 64'd0);
        check("t4_rst_last",    64'(i32.out_last),  64'd0);
        check("t4_rst_data",    64'(i32.out_data),  64'd0);
        check("t4_rst_overrun", 64'(i32.overrun),   64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cap32(r_seq, s_desc, 1'b1);
        drain32("t4_drain");
        check("t4_word_count", 64'(obs32.size()), 64'd16);

`ifdef SIG_RANGE_CHECK_EN
        // S = L rejected, S = L-1 streams
        cap32(r_seq, L_VAL, 1'b0);
        @(negedge clk);
        check("t5_err_pulse",    64'(i32.s_range_err), 64'd1);
        check("t5_no_valid",     64'(i32.out_valid),   64'd0);
        check("t5_cap_ready",    64'(i32.cap_ready),   64'd1);
        @(negedge clk);
        check("t5_err_one_cycle", 64'(i32.s_range_err), 64'd0);
        check("t5_still_idle",    64'(i32.out_valid),   64'd0);
        cap32(r_seq, L_VAL - 256'd1, 1'b1);
        @(negedge clk);
        check("t5_lm1_no_err", 64'(i32.s_range_err), 64'd0);
        drain32("t5_drain");
        check("t5_word_count", 64'(obs32.size()), 64'd16);
`else
        // Without range checking, S = L streams like any other value
        cap32(r_seq, L_VAL, 1'b1);
        @(negedge clk);
        check("t5_err_tied_low", 64'(i32.s_range_err), 64'd0);
        check("t5_valid",        64'(i32.out_valid),   64'd1);
        drain32("t5_drain");
        check("t5_word_count", 64'(obs32.size()), 64'd16);
`endif

        // Byte-wide instance
        @(posedge clk); #1;
        i8.sig_R     = r_seq;
        i8.core_S    = s_desc;
        i8.cap_valid = 1'b1;
        push_sig8(r_seq, s_desc);
        @(posedge clk); #1;
        i8.cap_valid = 1'b0;
        for (int i = 0; i < 400 && q8.size() != 0; i++) @(posedge clk);
        check("t6_drain", 64'(q8.size()), 64'd0);
        check("t6_byte_count", 64'(obs8.size()), 64'd64);
        if (obs8.size() == 64) begin
            check("t6_byte31", obs8[31], 64'h1f);
            check("t6_byte32", obs8[32], 64'h20);
            check("t6_byte63", obs8[63], 64'h01);
        end
        @(negedge clk);
        check("t6_idle_cap_ready", 64'(i8.cap_ready), 64'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
